// File: rtl/axis_packet_fifo_pkg.sv
// Shared types and helpers for the store-and-forward AXI-Stream packet FIFO.
// Holds the write-side FSM encoding and the pointer fill-level arithmetic.
package axis_packet_fifo_pkg;

  typedef enum logic {
    ST_STORE = 1'b0,
    ST_DROP  = 1'b1
  } fifo_state_t;

  // Occupancy of a ring addressed by ptr_bits-wide wrapping pointers.
  function automatic logic [31:0] ptr_fill(input logic [31:0] wr_ptr,
                                           input logic [31:0] rd_ptr,
                                           input int          ptr_bits);
    logic [31:0] mask;
    mask = (32'd1 << ptr_bits) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/axis_packet_fifo_if.sv
// AXI-Stream handshake bundle used on both sides of the packet FIFO.
// The master modport drives data/last/valid; the slave modport drives ready.
interface axis_packet_fifo_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_packet_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register doubles as the FIFO's output data register.
module axis_sdp_ram #(
  parameter int DWIDTH = 33,
  parameter int AWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // NOTE: the array has no reset so it maps onto block RAM; only committed entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: packets are released only once complete,
// the source is never stalled, and packets that overflow storage are dropped whole.
module axis_packet_fifo
  import axis_packet_fifo_pkg::*;
#(
  parameter int AXIS_DWIDTH = 32,
  parameter int DEPTH_LOG2  = 6,
  parameter int CFG_DWIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [CFG_DWIDTH-1:0] count_drop,
  input  logic                  count_clear,
  output logic [CFG_DWIDTH-1:0] pkt_count,
  axis_packet_fifo_if.slave     s,
  axis_packet_fifo_if.master    m
);

  localparam int PTR_W  = DEPTH_LOG2 + 1;
  localparam int DEPTH  = 2**DEPTH_LOG2;
  localparam int WORD_W = AXIS_DWIDTH + 1;

  fifo_state_t       state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, wr_commit, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt, wr_commit_nxt;
  logic              ready_r, valid_r;
  logic              beat, full, avail, rd_en, wr_en, commit, drop, pkt_out;
  logic [WORD_W-1:0] rd_word;

  assign beat    = s.tvalid & ready_r;
  assign full    = ptr_fill(32'(wr_ptr), 32'(rd_ptr), PTR_W) == 32'(DEPTH);
  // Only beats of completed packets are visible to the read side.
  assign avail   = wr_commit != rd_ptr;
  assign rd_en   = avail & (~valid_r | m.tready);
  assign pkt_out = valid_r & m.tready & rd_word[AXIS_DWIDTH];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    wr_en         = 1'b0;
    commit        = 1'b0;
    drop          = 1'b0;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    if (beat) begin
      case (state)
        ST_STORE: begin
          if (!full) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (s.tlast) begin
              commit        = 1'b1;
              wr_commit_nxt = wr_ptr + PTR_W'(1);
            end
          end else begin
            // Rewind over the partial packet and swallow the rest of it.
            drop       = 1'b1;
            wr_ptr_nxt = wr_commit;
            if (!s.tlast) state_nxt = ST_DROP;
          end
        end
        ST_DROP: begin
          if (s.tlast) state_nxt = ST_STORE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_STORE;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      rd_ptr     <= '0;
      ready_r    <= 1'b0;
      valid_r    <= 1'b0;
      count_drop <= '0;
      pkt_count  <= '0;
    end else begin
      ready_r   <= 1'b1;
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      wr_commit <= wr_commit_nxt;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        valid_r <= 1'b1;
      end else if (m.tready) begin
        valid_r <= 1'b0;
      end
      if (count_clear) count_drop <= '0;
      else if (drop)   count_drop <= count_drop + CFG_DWIDTH'(1);
      if (commit && !pkt_out)      pkt_count <= pkt_count + CFG_DWIDTH'(1);
      else if (!commit && pkt_out) pkt_count <= pkt_count - CFG_DWIDTH'(1);
    end
  end

  axis_sdp_ram #(
    .DWIDTH (WORD_W),
    .AWIDTH (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data ({s.tlast, s.tdata}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (rd_word)
  );

  assign s.tready = ready_r;
  assign m.tvalid = valid_r;
  assign m.tdata  = rd_word[AXIS_DWIDTH-1:0];
  // The read register keeps its last word after a drain; gate tlast so it never outlives tvalid.
  assign m.tlast  = valid_r & rd_word[AXIS_DWIDTH];

`ifdef FORMAL
  assume property (@(posedge clk) disable iff (!rst)
    s.tvalid |-> !$isunknown({s.tlast, s.tdata}));
  assert property (@(posedge clk) disable iff (!rst)
    m.tvalid && !m.tready |=> m.tvalid && $stable(m.tdata) && $stable(m.tlast));
  assert property (@(posedge clk) disable iff (!rst) m.tlast |-> m.tvalid);
  assert property (@(posedge clk) disable iff (!rst) 32'(pkt_count) <= 32'(DEPTH));
`endif

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Self-checking bench for axis_packet_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of storage, output register and counters.
module tb_axis_packet_fifo;
  import axis_packet_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DL2   = 3;
  localparam int CW    = 8;
  localparam int DEPTH = 2**DL2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          count_clear = 1'b0;
  logic [CW-1:0] count_drop, pkt_count;

  axis_packet_fifo_if #(.DWIDTH(DW)) s_bus ();
  axis_packet_fifo_if #(.DWIDTH(DW)) m_bus ();

  axis_packet_fifo #(
    .AXIS_DWIDTH (DW),
    .DEPTH_LOG2  (DL2),
    .CFG_DWIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .count_drop  (count_drop),
    .count_clear (count_clear),
    .pkt_count   (pkt_count),
    .s           (s_bus),
    .m           (m_bus)
  );

  always #5 clk = ~clk;

  // Reference model: beats of complete packets still in storage, the packet being
  // received, the word presented on m_*, and the drop counter.
  logic [DW:0]   mem_q[$];
  logic [DW:0]   part_q[$];
  logic [DW:0]   out_log[$];
  logic [DW:0]   out_word;
  bit            out_valid, dropping, src_ok;
  logic [CW-1:0] drops;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    part_q.delete();
    out_word  = '0;
    out_valid = 1'b0;
    dropping  = 1'b0;
    src_ok    = 1'b0;
    drops     = '0;
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit          full;
    bit          drop_ev;
    logic [DW:0] w;
    full    = (mem_q.size() + part_q.size()) == DEPTH;
    drop_ev = 1'b0;
    w       = {s_bus.tlast, s_bus.tdata};
    if (mem_q.size() > 0 && (!out_valid || m_bus.tready)) begin
      out_word  = mem_q.pop_front();
      out_valid = 1'b1;
    end else if (m_bus.tready) begin
      out_valid = 1'b0;
    end
    if (s_bus.tvalid && src_ok) begin
      if (dropping) begin
        if (w[DW]) dropping = 1'b0;
      end else if (full) begin
        part_q.delete();
        drop_ev  = 1'b1;
        dropping = !w[DW];
      end else begin
        part_q.push_back(w);
        if (w[DW]) begin
          mem_q = {mem_q, part_q};
          part_q.delete();
        end
      end
    end
    if (count_clear)  drops = '0;
    else if (drop_ev) drops++;
    src_ok = 1'b1;
  endtask

  function automatic int model_pkts();
    int n;
    n = (out_valid && out_word[DW]) ? 1 : 0;
    foreach (mem_q[i]) if (mem_q[i][DW]) n++;
    return n;
  endfunction

  task automatic check_outputs();
    check("s_tready",   64'(s_bus.tready), 64'(src_ok));
    check("m_tvalid",   64'(m_bus.tvalid), 64'(out_valid));
    check("m_tlast",    64'(m_bus.tlast),  64'(out_valid & out_word[DW]));
    if (out_valid) check("m_tdata", 64'(m_bus.tdata), 64'(out_word[DW-1:0]));
    check("pkt_count",  64'(pkt_count),    64'(model_pkts()));
    check("count_drop", 64'(count_drop),   64'(drops));
    check("fsm_drop",   64'(dut.state == ST_DROP), 64'(dropping));
  endtask

  // Called just after a rising edge; inputs stay put until the next edge.
  task automatic tick();
    @(negedge clk);
    if (m_bus.tvalid && m_bus.tready) out_log.push_back({m_bus.tlast, m_bus.tdata});
    model_edge();
    @(posedge clk);
    #1 check_outputs();
  endtask

  task automatic drive(input bit v, input bit l, input logic [DW-1:0] d, input bit rdy);
    s_bus.tvalid = v;
    s_bus.tlast  = l;
    s_bus.tdata  = d;
    m_bus.tready = rdy;
    tick();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, rdy);
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base, input bit rdy);
    for (int i = 0; i < len; i++) drive(1'b1, i == len - 1, base + DW'(i), rdy);
  endtask

  task automatic expect_log(input string tag, input logic [DW-1:0] base, input int len);
    check({tag, "_beats"}, 64'(out_log.size()), 64'(len));
    for (int i = 0; i < len && i < out_log.size(); i++)
      check(tag, 64'(out_log[i]), 64'({i == len - 1, base + DW'(i)}));
    out_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pct;
    bit rdy;
    s_bus.tvalid = 1'b0;
    s_bus.tlast  = 1'b0;
    s_bus.tdata  = '0;
    m_bus.tready = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #1 check_outputs();
    @(posedge clk);
    #1 check_outputs();
    rst = 1'b1;
    idle(1, 1'b1);
    check("ready_after_release", 64'(s_bus.tready), 64'(1));

    // 1: three-beat packet, first beat appears two cycles after tlast is accepted.
    out_log.delete();
    send_pkt(3, 32'hA, 1'b1);
    check("t1_valid_T1", 64'(m_bus.tvalid), 64'(0));
    idle(1, 1'b1);
    check("t1_valid_T2", 64'(m_bus.tvalid), 64'(1));
    check("t1_first",    64'(m_bus.tdata),  64'(32'hA));
    check("t1_pkts",     64'(pkt_count),    64'(1));
    idle(4, 1'b1);
    expect_log("t1", 32'hA, 3);
    check("t1_pkts_end", 64'(pkt_count), 64'(0));

    // 2: exactly-DEPTH packet is kept, the following one overflows and is dropped.
    send_pkt(DEPTH, 32'h100, 1'b0);
    send_pkt(2, 32'h200, 1'b0);
    check("t2_pkts",  64'(pkt_count),  64'(1));
    check("t2_drops", 64'(count_drop), 64'(1));
    idle(DEPTH + 4, 1'b1);
    expect_log("t2", 32'h100, DEPTH);

    // 3: over-long packet into an empty FIFO is dropped and the FSM swallows its tail.
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, i == DEPTH + 1, 32'h300 + DW'(i), 1'b1);
      if (i == DEPTH) check("t3_in_drop", 64'(dut.state == ST_DROP), 64'(1));
    end
    check("t3_store", 64'(dut.state == ST_STORE), 64'(1));
    check("t3_drops", 64'(count_drop), 64'(2));
    idle(4, 1'b1);
    check("t3_no_output", 64'(out_log.size()), 64'(0));

    // 4: ready toggling every cycle while an 8-beat packet drains.
    send_pkt(8, 32'h400, 1'b0);
    for (int i = 0; i < 24; i++) idle(1, i[0]);
    expect_log("t4", 32'h400, 8);

    // 5a: output tlast handshake in the same cycle another packet commits.
    send_pkt(1, 32'h500, 1'b0);
    idle(2, 1'b0);
    drive(1'b1, 1'b0, 32'h600, 1'b0);
    check("t5_pkts_before", 64'(pkt_count), 64'(1));
    drive(1'b1, 1'b1, 32'h601, 1'b1);
    check("t5_pkts_same", 64'(pkt_count), 64'(1));
    idle(6, 1'b1);
    out_log.delete();

    // 5b: count_clear in the same cycle as a drop leaves the counter at zero.
    send_pkt(DEPTH, 32'h700, 1'b0);
    send_pkt(1, 32'h800, 1'b0);
    check("t5_drops_before", 64'(count_drop), 64'(3));
    send_pkt(1, 32'h801, 1'b0);
    count_clear = 1'b1;
    send_pkt(1, 32'h802, 1'b0);
    count_clear = 1'b0;
    check("t5_clear_vs_drop", 64'(count_drop), 64'(0));
    idle(DEPTH + 6, 1'b1);
    out_log.delete();

    // 6: reset with two packets and a partial one held.
    send_pkt(2, 32'h900, 1'b0);
    send_pkt(2, 32'h910, 1'b0);
    send_pkt(1, 32'h920, 1'b1);
    drive(1'b1, 1'b0, 32'h921, 1'b0);
    s_bus.tvalid = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check("t6_valid",  64'(m_bus.tvalid), 64'(0));
    check("t6_pkts",   64'(pkt_count),    64'(0));
    check("t6_drops",  64'(count_drop),   64'(0));
    check_outputs();
    #1 rst = 1'b1;
    idle(1, 1'b1);
    out_log.delete();
    send_pkt(3, 32'hA00, 1'b1);
    idle(6, 1'b1);
    expect_log("t6", 32'hA00, 3);

    // Randomized traffic with varying back-pressure regimes and occasional clears.
    for (int p = 0; p < 300; p++) begin
      int len;
      len = int'($urandom_range(1, DEPTH + 3));
      pct = ((p / 40) % 3 == 0) ? 15 : (((p / 40) % 3 == 1) ? 55 : 95);
      for (int b = 0; b < len; b++) begin
        int gaps;
        gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int g = 0; g < gaps; g++) begin
          rdy = $urandom_range(0, 99) < pct;
          idle(1, rdy);
        end
        rdy = $urandom_range(0, 99) < pct;
        count_clear = ($urandom_range(0, 63) == 0);
        drive(1'b1, b == len - 1, $urandom, rdy);
        count_clear = 1'b0;
      end
    end

    for (int i = 0; i < 200 && (pkt_count != 0 || m_bus.tvalid); i++) idle(1, 1'b1);
    check("drain_pkts",  64'(pkt_count),    64'(0));
    check("drain_valid", 64'(m_bus.tvalid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
